// File: rtl/lsu_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
package lsu_pkg;

    // Access sequencing: IDLE -> REQ -> WAIT -> DONE -> IDLE
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    // Access size as encoded in funct3
    typedef logic [2:0] mem_size_t;

    localparam mem_size_t LSU_B  = 3'b000;
    localparam mem_size_t LSU_H  = 3'b001;
    localparam mem_size_t LSU_W  = 3'b010;
    localparam mem_size_t LSU_BU = 3'b100;
    localparam mem_size_t LSU_HU = 3'b101;

    localparam logic [3:0] BE_B    = 4'b0001;
    localparam logic [3:0] BE_H_LO = 4'b0011;
    localparam logic [3:0] BE_H_HI = 4'b1100;
    localparam logic [3:0] BE_W    = 4'b1111;

    // Halfwords need an even address, words need a 4-byte aligned address.
    // Reserved funct3 codes are treated as word accesses.
    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] off);
        logic mis;
        case (size)
            LSU_B, LSU_BU: mis = 1'b0;
            LSU_H, LSU_HU: mis = off[0];
            default:       mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store data replication / byte enables and
// load data extraction with sign or zero extension. Purely combinational.
module lsu_align
    import lsu_pkg::*;
(
    input  mem_size_t   st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    input  mem_size_t   ld_size,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shift;

    assign ld_shift = ld_word >> {ld_off, 3'b000};

    // Store: replicate the item across all lanes, enable only the addressed bytes
    always_comb begin
        st_wdata = st_data;
        st_be    = BE_W;
        case (st_size)
            LSU_B, LSU_BU: begin
                st_wdata = {4{st_data[7:0]}};
                st_be    = BE_B << st_off;
            end
            LSU_H, LSU_HU: begin
                st_wdata = {2{st_data[15:0]}};
                st_be    = st_off[1] ? BE_H_HI : BE_H_LO;
            end
            default: begin
                st_wdata = st_data;
                st_be    = BE_W;
            end
        endcase
    end

    // Load: bring the addressed item down to bit 0, then extend
    always_comb begin
        ld_data = ld_shift;
        case (ld_size)
            LSU_B:   ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            LSU_BU:  ld_data = {24'h0, ld_shift[7:0]};
            LSU_H:   ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            LSU_HU:  ld_data = {16'h0, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit of the RV32I pipeline. Issues one word-aligned
// request per load/store on a req/gnt/rvalid bus and stalls the pipeline until
// the access completes. Misaligned accesses are dropped with a one-cycle flag.
// Optional build macro LSU_PERF_CNT_EN adds stall-cycle and access counters.
//
//  state | meaning
//  IDLE  | no access in flight; latch a new aligned access
//  REQ   | bus_req_o held with stable address/data until bus_gnt_i
//  WAIT  | granted, waiting for bus_rvalid_i (read data or write ack)
//  DONE  | access complete for one cycle, pipeline released
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  MemRead_i,
    input  logic                  MemWrite_i,
    input  logic [2:0]            MemCtrl_i,
    input  logic [ADDR_WIDTH-1:0] ALUout_i,
    input  logic [31:0]           WriteData_i,
    output logic                  stall_o,
    output logic [31:0]           DataMemOut_o,
    output logic                  misalign_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [31:0]           bus_wdata_o,
    output logic [3:0]            bus_be_o,
    input  logic                  bus_gnt_i,
    input  logic                  bus_rvalid_i,
    input  logic [31:0]           bus_rdata_i
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cnt_o,
    output logic [31:0]           access_cnt_o
`endif
);

    lsu_state_t            state_q;
    mem_size_t             size_q;
    logic [1:0]            off_q;
    logic [31:0]           dout_q;
    logic                  req_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            be_q;

    logic                  access;
    logic                  misaligned;
    logic [31:0]           st_wdata;
    logic [3:0]            st_be;
    logic [31:0]           ld_data;

    assign access     = MemRead_i | MemWrite_i;
    assign misaligned = access & is_misaligned(MemCtrl_i, ALUout_i[1:0]);

    // Inputs stay frozen while stalled, so the misalignment test is valid in every state
    assign stall_o    = access & (state_q != DONE) & ~misaligned;
    assign misalign_o = misaligned & (state_q == IDLE);

    // A dropped access reads as zero in the same cycle it is flagged
    assign DataMemOut_o = misalign_o ? 32'h0 : dout_q;

    assign bus_req_o   = req_q;
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;
    assign bus_be_o    = be_q;

    lsu_align u_align (
        .st_size  (MemCtrl_i),
        .st_off   (ALUout_i[1:0]),
        .st_data  (WriteData_i),
        .st_wdata (st_wdata),
        .st_be    (st_be),
        .ld_size  (size_q),
        .ld_off   (off_q),
        .ld_word  (bus_rdata_i),
        .ld_data  (ld_data)
    );

    // Access sequencer with registered bus outputs and load result
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            size_q  <= LSU_B;
            off_q   <= 2'b00;
            dout_q  <= 32'h0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (misaligned) begin
                        dout_q <= 32'h0;
                    end else if (access) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        // a simultaneous read and write is performed as a load
                        we_q    <= MemWrite_i & ~MemRead_i;
                        addr_q  <= {ALUout_i[ADDR_WIDTH-1:2], 2'b00};
                        wdata_q <= st_wdata;
                        be_q    <= st_be;
                        size_q  <= MemCtrl_i;
                        off_q   <= ALUout_i[1:0];
                    end
                end
                REQ: begin
                    if (bus_gnt_i) begin
                        state_q <= WAIT;
                        req_q   <= 1'b0;
                    end
                end
                WAIT: begin
                    if (bus_rvalid_i) begin
                        state_q <= DONE;
                        if (!we_q) begin
                            dout_q <= ld_data;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef LSU_PERF_CNT_EN
    // Free-running performance counters, wrapping naturally at 2^32
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_o  <= 32'h0;
            access_cnt_o <= 32'h0;
        end else begin
            if (stall_o) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            if (state_q == DONE) begin
                access_cnt_o <= access_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a simple req/gnt/rvalid responder.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [2:0]  MemCtrl_i;
    logic [31:0] ALUout_i;
    logic [31:0] WriteData_i;
    logic        stall_o;
    logic [31:0] DataMemOut_o;
    logic        misalign_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;
`ifdef LSU_PERF_CNT_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] access_cnt_o;
`endif

    int total = 0;
    int bad   = 0;

    // observations of the last access
    int          obs_stall;
    int          obs_reqs;
    logic        obs_done;
    logic        obs_stable;
    logic [31:0] obs_dout;
    logic [31:0] obs_addr;
    logic [31:0] obs_wdata;
    logic [3:0]  obs_be;
    logic        obs_we;

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .MemRead_i    (MemRead_i),
        .MemWrite_i   (MemWrite_i),
        .MemCtrl_i    (MemCtrl_i),
        .ALUout_i     (ALUout_i),
        .WriteData_i  (WriteData_i),
        .stall_o      (stall_o),
        .DataMemOut_o (DataMemOut_o),
        .misalign_o   (misalign_o),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_be_o     (bus_be_o),
        .bus_gnt_i    (bus_gnt_i),
        .bus_rvalid_i (bus_rvalid_i),
        .bus_rdata_i  (bus_rdata_i)
`ifdef LSU_PERF_CNT_EN
        ,
        .stall_cnt_o  (stall_cnt_o),
        .access_cnt_o (access_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        MemRead_i   = 1'b0;
        MemWrite_i  = 1'b0;
        MemCtrl_i   = 3'b000;
        ALUout_i    = 32'h0;
        WriteData_i = 32'h0;
        bus_gnt_i   = 1'b0;
        bus_rvalid_i = 1'b0;
    endtask

    // Present one access at posedge+1 and play the bus slave: grant after
    // gnt_delay request cycles, rvalid the cycle after the grant. Returns
    // at posedge+1 of the cycle after DONE with inputs idle.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rdata, input int gnt_delay);
        int waited;
        MemRead_i   = rd;
        MemWrite_i  = wr;
        MemCtrl_i   = f3;
        ALUout_i    = addr;
        WriteData_i = wd;
        bus_rdata_i = rdata;
        obs_stall   = 0;
        obs_reqs    = 0;
        obs_done    = 1'b0;
        obs_stable  = 1'b1;
        obs_dout    = 32'h0;
        waited      = 0;
        for (int cyc = 0; cyc < 40 && !obs_done; cyc++) begin
            bus_rvalid_i = bus_gnt_i;
            bus_gnt_i    = 1'b0;
            #1;
            if (!stall_o) begin
                obs_done = 1'b1;
                obs_dout = DataMemOut_o;
            end else begin
                obs_stall++;
                if (bus_req_o) begin
                    if (obs_reqs == 0) begin
                        obs_addr  = bus_addr_o;
                        obs_wdata = bus_wdata_o;
                        obs_be    = bus_be_o;
                        obs_we    = bus_we_o;
                    end else if (bus_addr_o !== obs_addr || bus_wdata_o !== obs_wdata ||
                                 bus_be_o !== obs_be || bus_we_o !== obs_we) begin
                        obs_stable = 1'b0;
                    end
                    obs_reqs++;
                    if (waited == gnt_delay) bus_gnt_i = 1'b1;
                    else waited++;
                end
            end
            @(posedge clk_i);
            #1;
        end
        idle_inputs();
        check("access_completes", {31'h0, obs_done}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        bus_rdata_i = 32'h0;
        rst_ni = 1'b0;
        tick();
        tick();
        check("rst_req",   {31'h0, bus_req_o}, 32'h0);
        check("rst_we",    {31'h0, bus_we_o}, 32'h0);
        check("rst_addr",  bus_addr_o, 32'h0);
        check("rst_wdata", bus_wdata_o, 32'h0);
        check("rst_be",    {28'h0, bus_be_o}, 32'h0);
        check("rst_dout",  DataMemOut_o, 32'h0);
        check("rst_mis",   {31'h0, misalign_o}, 32'h0);
        check("rst_stall", {31'h0, stall_o}, 32'h0);
        rst_ni = 1'b1;
        tick();

        // SW 0x104
        do_access(1'b0, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 0);
        check("sw_addr",  obs_addr, 32'h104);
        check("sw_be",    {28'h0, obs_be}, 32'hF);
        check("sw_wdata", obs_wdata, 32'hDEADBEEF);
        check("sw_we",    {31'h0, obs_we}, 32'h1);
        check("sw_stall", obs_stall, 3);

        // LB / LBU at byte 3
        do_access(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF00AA, 0);
        check("lb_addr", obs_addr, 32'h200);
        check("lb_we",   {31'h0, obs_we}, 32'h0);
        check("lb_dout", obs_dout, 32'hFFFFFF80);
        check("lb_hold", DataMemOut_o, 32'hFFFFFF80);
        do_access(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF00AA, 0);
        check("lbu_dout", obs_dout, 32'h00000080);

        // SB at byte 1
        do_access(1'b0, 1'b1, 3'b000, 32'h101, 32'h000000A5, 32'h0, 0);
        check("sb_be",    {28'h0, obs_be}, 32'h2);
        check("sb_wdata", obs_wdata, 32'hA5A5A5A5);

        // SH / LHU / LH at upper half
        do_access(1'b0, 1'b1, 3'b001, 32'h12, 32'h0000BEEF, 32'h0, 0);
        check("sh_addr",  obs_addr, 32'h10);
        check("sh_be",    {28'h0, obs_be}, 32'hC);
        check("sh_wdata", obs_wdata, 32'hBEEFBEEF);
        do_access(1'b1, 1'b0, 3'b101, 32'h12, 32'h0, 32'hBEEF1234, 0);
        check("lhu_dout", obs_dout, 32'h0000BEEF);
        do_access(1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 32'hBEEF1234, 0);
        check("lh_dout", obs_dout, 32'hFFFFBEEF);

        // Read and write together behave as a load
        do_access(1'b1, 1'b1, 3'b010, 32'h80, 32'h55555555, 32'h13572468, 0);
        check("rw_we",   {31'h0, obs_we}, 32'h0);
        check("rw_dout", obs_dout, 32'h13572468);

        // Misaligned LW at 0x6
        MemRead_i = 1'b1;
        MemCtrl_i = 3'b010;
        ALUout_i  = 32'h6;
        #1;
        check("mis_pulse", {31'h0, misalign_o}, 32'h1);
        check("mis_stall", {31'h0, stall_o}, 32'h0);
        check("mis_dout",  DataMemOut_o, 32'h0);
        check("mis_req",   {31'h0, bus_req_o}, 32'h0);
        @(posedge clk_i);
        #1;
        idle_inputs();
        #1;
        check("mis_end",   {31'h0, misalign_o}, 32'h0);
        check("mis_req2",  {31'h0, bus_req_o}, 32'h0);
        check("mis_dout2", DataMemOut_o, 32'h0);
        tick();

        // Grant withheld five cycles
        do_access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h11223344, 5);
        check("slow_reqs",   obs_reqs, 6);
        check("slow_stable", {31'h0, obs_stable}, 32'h1);
        check("slow_stall",  obs_stall, 8);
        check("slow_dout",   obs_dout, 32'h11223344);

        // Stray rvalid in IDLE
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'hFFFFFFFF;
        tick();
        bus_rvalid_i = 1'b0;
        #1;
        check("stray_dout",  DataMemOut_o, 32'h11223344);
        check("stray_req",   {31'h0, bus_req_o}, 32'h0);
        check("stray_stall", {31'h0, stall_o}, 32'h0);

        // Reset while a store is in WAIT
        MemWrite_i  = 1'b1;
        MemCtrl_i   = 3'b010;
        ALUout_i    = 32'h20;
        WriteData_i = 32'h12345678;
        tick();
        bus_gnt_i = 1'b1;
        tick();
        bus_gnt_i = 1'b0;
        #1;
        check("pre_rst_we", {31'h0, bus_we_o}, 32'h1);
        rst_ni = 1'b0;
        idle_inputs();
        #1;
        check("mid_rst_req",   {31'h0, bus_req_o}, 32'h0);
        check("mid_rst_we",    {31'h0, bus_we_o}, 32'h0);
        check("mid_rst_addr",  bus_addr_o, 32'h0);
        check("mid_rst_wdata", bus_wdata_o, 32'h0);
        check("mid_rst_be",    {28'h0, bus_be_o}, 32'h0);
        check("mid_rst_dout",  DataMemOut_o, 32'h0);
        check("mid_rst_stall", {31'h0, stall_o}, 32'h0);
`ifdef LSU_PERF_CNT_EN
        check("mid_rst_scnt", stall_cnt_o, 32'h0);
        check("mid_rst_acnt", access_cnt_o, 32'h0);
`endif
        tick();
        rst_ni       = 1'b1;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'hA5A5A5A5;
        tick();
        bus_rvalid_i = 1'b0;
        #1;
        check("late_rvalid_dout", DataMemOut_o, 32'h0);
        check("late_rvalid_req",  {31'h0, bus_req_o}, 32'h0);
        tick();

        // Normal LW at 0x0 after reset
        do_access(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 32'hCAFEF00D, 0);
        check("post_rst_addr",  obs_addr, 32'h0);
        check("post_rst_dout",  obs_dout, 32'hCAFEF00D);
        check("post_rst_stall", obs_stall, 3);
`ifdef LSU_PERF_CNT_EN
        check("post_rst_scnt", stall_cnt_o, 32'd3);
        check("post_rst_acnt", access_cnt_o, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
